// File: rtl/mc_maindec.sv
// Multicycle main decoder: Moore FSM that sequences the datapath through
// fetch, decode and the per-instruction execute/memory/writeback steps.
// Control outputs are registered alongside the state, so they are a pure
// function of the current state; only pcen mixes in the live zero flag.
module mc_maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [3:0] state,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur, nxt;
    ctrl_t  ctrl;

    // Control word for a given state; unused encodings drive everything low.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state: op is only looked at in DECODE and MEMADR.
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYP:      nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;   // unknown opcode is skipped
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      nxt = MEMRD;
                else if (op == OP_SW) nxt = MEMWR;
                else                  nxt = FETCH;
            end
            MEMRD:   nxt = MEMWB;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;   // writeback/branch/jump ends and unused codes
        endcase
    end

    // State and control word registered together; reset lands in FETCH at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= FETCH;
            ctrl <= ctrl_of(FETCH);
        end else begin
            cur  <= nxt;
            ctrl <= ctrl_of(nxt);
        end
    end

    assign state    = cur;
    assign aluop    = ctrl.aluop;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign iord     = ctrl.iord;
    assign irwrite  = ctrl.irwrite;
    assign memwrite = ctrl.memwrite;
    assign regwrite = ctrl.regwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;

    // Branch taken needs the live zero flag, so the PC enable stays combinational.
    assign pcen = ctrl.pcwrite | (ctrl.branch & zero);

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  asynchronous, active-high reset; forces state FETCH immediately, independent of clk.
REQ-004 op  input  6  opcode field instr[31:26] of the instruction register.
REQ-005 zero  input  1  ALU zero flag, used only in BRANCH.
REQ-006 state  output  4  current state encoding, for the monitor.
REQ-007 aluop  output  2  ALU operation class: 00 add, 01 subtract, 10 decode funct; drives the ALU decoder.
REQ-008 alusrca  output  1  ALU A source: 0 = PC, 1 = register A.
REQ-009 alusrcb  output  2  ALU B source: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-010 pcsrc  output  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-011 iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch  output  1 each  datapath strobes and selects.
REQ-012 pcen  output  1  PC register enable.

Function
REQ-013 The block SHALL be a Moore FSM: every output except pcen depends only on the registered state.
REQ-014 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 Fixed transitions: FETCH->DECODE; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB. MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP each go to FETCH.
REQ-016 DECODE transitions by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP; any other op -> FETCH (instruction skipped, no architectural write).
REQ-017 MEMADR transitions: op=100011 -> MEMRD; op=101011 -> MEMWR; any other op -> FETCH.
REQ-018 Unused encodings 12-15 SHALL go to FETCH on the next clock, and all outputs SHALL be 0 while in them.
REQ-019 Active outputs per state; every output not listed SHALL be 0:
  FETCH: alusrcb=01, irwrite=1, pcwrite=1.
  DECODE: alusrcb=11.
  MEMADR: alusrca=1, alusrcb=10.
  MEMRD: iord=1.
  MEMWB: memtoreg=1, regwrite=1.
  MEMWR: iord=1, memwrite=1.
  EXECUTE: alusrca=1, aluop=10.
  ALUWB: regdst=1, regwrite=1.
  BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  ADDIEX: alusrca=1, alusrcb=10.
  ADDIWB: regwrite=1.
  JUMP: pcsrc=10, pcwrite=1.
REQ-020 pcen SHALL be combinational: pcen = pcwrite OR (branch AND zero).
REQ-021 Latency in cycles from FETCH back to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
REQ-022 A change on op outside DECODE and MEMADR SHALL NOT affect the state path.

Reset
REQ-023 When reset is asserted: state=0 (FETCH) without waiting for a clock edge; outputs take the FETCH values (irwrite=1, pcwrite=1, pcen=1, alusrcb=01, all other outputs 0).
REQ-024 Reset asserted in any state SHALL abort the instruction in progress; the first rising clk edge after reset deasserts SHALL move FETCH->DECODE.

Verification
REQ-025 lw: reset, then op=100011 held -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-026 beq: op=000100 with zero=1 in BRANCH -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; next state is 0 in both cases.
REQ-027 Illegal op 111111 -> state sequence 0,1,0; memwrite=0 and regwrite=0 throughout.
REQ-028 R-type: op=000000 -> state sequence 0,1,6,7,0; aluop=10 in state 6 only; regdst=1 in state 7.
REQ-029 Asynchronous reset mid-sw: assert reset between clock edges while in MEMWR (state 5) -> state=0 and memwrite=0 before the next clk edge.
REQ-030 Sweep all 64 op values through DECODE -> next state matches REQ-016 for every value.
